// File: rtl/l15_playback_player.sv
// Replays captured L1.5 boundary records into a bare l15 and checks its outputs
// against the capture, one record per clock, reporting pass/fail and first-failure data.
module l15_playback_player #(
  parameter int IN_W   = 357,
  parameter int OUT_W  = 371,
  parameter int ADDR_W = 16,
  parameter int REC_W  = 1 + IN_W + OUT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_records,
  input  logic              stop_on_err,
  input  logic [OUT_W-1:0]  cmp_mask,
  output logic              vec_rd_en,
  output logic [ADDR_W-1:0] vec_addr,
  input  logic [REC_W-1:0]  vec_rd_data,
  output logic [IN_W-1:0]   dut_in,
  input  logic [OUT_W-1:0]  dut_out,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] skip_count,
  output logic [ADDR_W-1:0] first_err_idx,
  output logic [OUT_W-1:0]  first_err_xor,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] n_q;
  logic              stop_q;
  logic              rd_valid_q;
  logic [ADDR_W-1:0] rd_idx_q;
  logic [OUT_W-1:0]  exp_vec_q;
  logic              cmp_valid_q;
  logic [ADDR_W-1:0] cmp_idx_q;

  logic              start_ok;
  logic [OUT_W-1:0]  masked_xor;
  logic              mismatch;
  logic              stop_now;
  logic              rec_flag;
  logic [ADDR_W-1:0] n_last;
  logic              last_load;

  // Memory handshake: no backpressure. A cycle with vec_rd_en=1 at vec_addr
  // returns that record on vec_rd_data in the following cycle, unconditionally.
  assign start_ok   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign masked_xor = (dut_out ^ exp_vec_q) & cmp_mask;
  assign mismatch   = cmp_valid_q && (|masked_xor);
  assign stop_now   = mismatch && stop_q;
  assign rec_flag   = vec_rd_data[REC_W-1];
  assign n_last     = n_q - 1'b1;
  assign last_load  = rd_valid_q && (rd_idx_q == n_last);

  assign busy      = (state_q == S_FILL) || (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) state_d = (num_records == '0) ? S_DONE : S_FILL;
      end
      S_FILL:  state_d = S_RUN;
      S_RUN: begin
        if (stop_now)       state_d = S_DONE;
        else if (last_load) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      n_q           <= '0;
      stop_q        <= 1'b0;
      vec_rd_en     <= 1'b0;
      vec_addr      <= '0;
      rd_valid_q    <= 1'b0;
      rd_idx_q      <= '0;
      dut_in        <= '0;
      exp_vec_q     <= '0;
      cmp_valid_q   <= 1'b0;
      cmp_idx_q     <= '0;
      err_count     <= '0;
      skip_count    <= '0;
      fail          <= 1'b0;
      first_err_idx <= '0;
      first_err_xor <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        n_q           <= num_records;
        stop_q        <= stop_on_err;
        vec_rd_en     <= (num_records != '0);
        vec_addr      <= '0;
        rd_valid_q    <= 1'b0;
        cmp_valid_q   <= 1'b0;
        err_count     <= '0;
        skip_count    <= '0;
        fail          <= 1'b0;
        first_err_idx <= '0;
        first_err_xor <= '0;
      end else if (busy) begin
        if (stop_now) begin
          vec_rd_en <= 1'b0;
        end else if (vec_rd_en) begin
          if (vec_addr == n_last) vec_rd_en <= 1'b0;
          else                    vec_addr  <= vec_addr + 1'b1;
        end
        rd_valid_q  <= vec_rd_en && !stop_now;
        rd_idx_q    <= vec_addr;
        cmp_valid_q <= 1'b0;

        // Flag-0 records are pre-clock samples: counted, never driven or compared.
        if (rd_valid_q && !stop_now) begin
          if (rec_flag) begin
            dut_in      <= vec_rd_data[OUT_W +: IN_W];
            exp_vec_q   <= vec_rd_data[OUT_W-1:0];
            cmp_valid_q <= 1'b1;
            cmp_idx_q   <= rd_idx_q;
          end else begin
            skip_count  <= skip_count + 1'b1;
          end
        end

        if (mismatch) begin
          if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
          fail <= 1'b1;
          if (!fail) begin
            first_err_idx <= cmp_idx_q;
            first_err_xor <= masked_xor;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_l15_playback_player.sv
// Bench for l15_playback_player: vector memory model, looped-back L1.5 model with
// injectable bit-5 faults, table of runs plus hand sequences for n=0 and mid-run reset.
module tb_l15_playback_player;

  localparam int IN_W   = 357;
  localparam int OUT_W  = 371;
  localparam int ADDR_W = 16;
  localparam int REC_W  = 1 + IN_W + OUT_W;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] num_records;
  logic              stop_on_err;
  logic [OUT_W-1:0]  cmp_mask;
  logic              vec_rd_en;
  logic [ADDR_W-1:0] vec_addr;
  logic [REC_W-1:0]  vec_rd_data;
  logic [IN_W-1:0]   dut_in;
  logic [OUT_W-1:0]  dut_out;
  logic              busy;
  logic              done;
  logic              fail;
  logic [15:0]       err_count;
  logic [ADDR_W-1:0] skip_count;
  logic [ADDR_W-1:0] first_err_idx;
  logic [OUT_W-1:0]  first_err_xor;
  logic [2:0]        dbg_state;

  l15_playback_player #(.IN_W(IN_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_records(num_records),
    .stop_on_err(stop_on_err), .cmp_mask(cmp_mask), .vec_rd_en(vec_rd_en),
    .vec_addr(vec_addr), .vec_rd_data(vec_rd_data), .dut_in(dut_in),
    .dut_out(dut_out), .busy(busy), .done(done), .fail(fail),
    .err_count(err_count), .skip_count(skip_count),
    .first_err_idx(first_err_idx), .first_err_xor(first_err_xor),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory and L1.5 models ----------------
  logic [REC_W-1:0] mem [0:15];
  logic [IN_W-1:0]  rec_in [0:15];
  int               cur_n;
  logic [15:0]      cur_fault;
  logic [OUT_W-1:0] fault_x;

  function automatic logic [OUT_W-1:0] model_out(input logic [IN_W-1:0] x);
    return {x[13:0], ~x};
  endfunction

  function automatic logic [IN_W-1:0] rand_in();
    logic [IN_W-1:0] v;
    v = '0;
    for (int b = 0; b < IN_W; b += 32) v = (v << 32) | IN_W'($urandom);
    return v;
  endfunction

  always @(posedge clk) if (vec_rd_en) vec_rd_data <= mem[vec_addr[3:0]];

  always_comb begin
    fault_x = '0;
    for (int i = 0; i < 16; i++)
      if (i < cur_n && cur_fault[i] && dut_in == rec_in[i]) fault_x = OUT_W'(32'h20);
    dut_out = model_out(dut_in) ^ fault_x;
  end

  // ---------------- scoreboard ----------------
  logic [IN_W-1:0] exp_q[$];
  logic [IN_W-1:0] model_dut_in;
  int n_checks;
  int n_err;

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    int          n;
    bit          stop;
    bit          mask5;
    logic [15:0] skip_m;
    logic [15:0] fault_m;
    int          exp_err;
    int          exp_skip;
    int          exp_idx;
    bit          exp_fail;
    int          exp_done;
    int          poke;
  } case_t;

  case_t tcs [0:6];

  // ---------------- driver ----------------
  task automatic run_case(input int id, input case_t tc);
    logic [IN_W-1:0]  held;
    logic [IN_W-1:0]  got;
    logic [OUT_W-1:0] full_mask;
    int done_c;
    string p;
    p = $sformatf("case%0d", id);
    cur_n = 0;
    cur_fault = tc.fault_m;
    for (int i = 0; i < tc.n; i++) begin
      rec_in[i] = rand_in();
      mem[i] = {~tc.skip_m[i], rec_in[i], model_out(rec_in[i])};
    end
    cur_n = tc.n;
    held = model_dut_in;
    for (int i = 0; i < tc.n; i++) begin
      if (!tc.skip_m[i]) held = rec_in[i];
      exp_q.push_back(held);
    end
    full_mask = '1;
    cmp_mask = tc.mask5 ? full_mask : (full_mask & ~OUT_W'(32'h20));

    @(negedge clk);
    start = 1'b1; num_records = ADDR_W'(tc.n); stop_on_err = tc.stop;
    @(posedge clk); #1;
    start = 1'b0;
    chk({p, "_rd_en0"}, 512'(vec_rd_en), 512'(1));
    chk({p, "_addr0"}, 512'(vec_addr), 512'(0));

    done_c = -1;
    for (int c = 1; c <= 40 && done_c < 0; c++) begin
      @(posedge clk); #1;
      if (start) start = 1'b0;
      if (c == tc.poke) begin
        start = 1'b1; num_records = ADDR_W'(1);
      end
      if (c < tc.n && c < tc.exp_done) begin
        chk($sformatf("%s_rd_en%0d", p, c), 512'(vec_rd_en), 512'(1));
        chk($sformatf("%s_addr%0d", p, c), 512'(vec_addr), 512'(c));
      end
      if (c >= 2 && c < tc.exp_done && exp_q.size() > 0) begin
        got = exp_q.pop_front();
        model_dut_in = got;
        chk($sformatf("%s_dut_in%0d", p, c), 512'(dut_in), 512'(got));
      end
      if (done) done_c = c;
    end
    start = 1'b0;
    exp_q.delete();

    chk({p, "_done_cycle"}, 512'(done_c), 512'(tc.exp_done));
    chk({p, "_err_count"}, 512'(err_count), 512'(tc.exp_err));
    chk({p, "_skip_count"}, 512'(skip_count), 512'(tc.exp_skip));
    chk({p, "_fail"}, 512'(fail), 512'(tc.exp_fail));
    chk({p, "_first_idx"}, 512'(first_err_idx), 512'(tc.exp_idx));
    chk({p, "_first_xor"}, 512'(first_err_xor), (tc.exp_err > 0) ? 512'h20 : 512'h0);
    chk({p, "_busy_end"}, 512'(busy), 512'(0));
    chk({p, "_rd_en_end"}, 512'(vec_rd_en), 512'(0));
    chk({p, "_dut_in_end"}, 512'(dut_in), 512'(model_dut_in));
    if (!tc.stop) chk({p, "_addr_end"}, 512'(vec_addr), 512'(tc.n - 1));
  endtask

  task automatic check_all_zero(input string p);
    chk({p, "_busy"}, 512'(busy), 512'(0));
    chk({p, "_done"}, 512'(done), 512'(0));
    chk({p, "_fail"}, 512'(fail), 512'(0));
    chk({p, "_rd_en"}, 512'(vec_rd_en), 512'(0));
    chk({p, "_addr"}, 512'(vec_addr), 512'(0));
    chk({p, "_dut_in"}, 512'(dut_in), 512'(0));
    chk({p, "_err"}, 512'(err_count), 512'(0));
    chk({p, "_skip"}, 512'(skip_count), 512'(0));
    chk({p, "_idx"}, 512'(first_err_idx), 512'(0));
    chk({p, "_xor"}, 512'(first_err_xor), 512'(0));
    chk({p, "_state"}, 512'(dbg_state), 512'(0));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    n_checks = 0; n_err = 0;
    rst_n = 1'b0; start = 1'b0; num_records = '0; stop_on_err = 1'b0;
    cmp_mask = '1; cur_n = 0; cur_fault = '0; model_dut_in = '0;
    for (int i = 0; i < 16; i++) begin mem[i] = '0; rec_in[i] = '0; end

    //         n  stop mask skip_m      fault_m     err skip idx fail done poke
    tcs[0] = '{4,  0,  1,   16'h0000,   16'h0000,   0,  0,   0,  0,   6,  -1};
    tcs[1] = '{6,  0,  1,   16'h000A,   16'h0000,   0,  2,   0,  0,   8,  -1};
    tcs[2] = '{8,  0,  1,   16'h0000,   16'h0044,   2,  0,   2,  1,   10, -1};
    tcs[3] = '{8,  0,  0,   16'h0000,   16'h0044,   0,  0,   0,  0,   10, -1};
    tcs[4] = '{8,  1,  1,   16'h0000,   16'h0004,   1,  0,   2,  1,   5,  -1};
    tcs[5] = '{10, 0,  1,   16'h0201,   16'h0010,   1,  2,   4,  1,   12, -1};
    tcs[6] = '{4,  0,  1,   16'h0000,   16'h0000,   0,  0,   0,  0,   6,   2};

    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_all_zero("idle");

    for (int t = 0; t < 7; t++) run_case(t, tcs[t]);

    // Stop-on-error leaves fail set; an n=0 start must clear it and finish at once.
    run_case(7, tcs[4]);
    @(negedge clk);
    start = 1'b1; num_records = '0; stop_on_err = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("n0_done", 512'(done), 512'(1));
    chk("n0_busy", 512'(busy), 512'(0));
    chk("n0_fail", 512'(fail), 512'(0));
    chk("n0_err", 512'(err_count), 512'(0));
    chk("n0_dut_in_hold", 512'(dut_in), 512'(model_dut_in));

    // Reset in the middle of a run.
    for (int i = 0; i < 8; i++) begin
      rec_in[i] = rand_in();
      mem[i] = {1'b1, rec_in[i], model_out(rec_in[i])};
    end
    cur_n = 8; cur_fault = '0; cmp_mask = '1;
    @(negedge clk);
    start = 1'b1; num_records = ADDR_W'(8); stop_on_err = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_busy_before", 512'(busy), 512'(1));
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    check_all_zero("midrst");
    model_dut_in = '0;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_done", 512'(done), 512'(0));
    chk("post_rst_rd_en", 512'(vec_rd_en), 512'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
